// File: rtl/stage3_uop_queue.sv
// stage3_uop_queue
// Circular buffer of fetched instructions (instr, pc, fault, mal) sitting
// between fetch and execute. Read side is combinational from the head entry,
// so an entry pushed in cycle N is visible to execute in cycle N+1.
// enq_ready / is_queue_full depend on the entry count only, so there is no
// combinational path from deq_ready back to fetch.
// Optional feature: define UOP_QUEUE_BYPASS_EN to add a zero-latency path
// that forwards enq_* straight to the deq side while the queue is empty.
module stage3_uop_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       enq_valid,
    input  logic [31:0]                enq_instr,
    input  logic [31:0]                enq_pc,
    input  logic                       enq_fault,
    input  logic                       enq_mal,
    output logic                       enq_ready,
    output logic                       valid_decode,
    output logic [31:0]                deq_instr,
    output logic [31:0]                pc_decode,
    output logic                       deq_fault,
    output logic                       deq_mal,
    input  logic                       deq_ready,
    input  logic                       stall_queue,
    input  logic                       flush_queue,
    output logic                       is_queue_full,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 66;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]              rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]              wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]              count_reg, count_next;
    logic [DEPTH-1:0][ENTRY_W-1:0] entry_q;
    logic [ENTRY_W-1:0]            wr_data;
    logic [ENTRY_W-1:0]            head_data;
    logic                          is_empty;
    logic                          is_full;
    logic                          push;
    logic                          pop;
    logic                          bypass_active;
    logic                          bypass_take;
    logic                          do_write;
    logic                          do_pop;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == FULL_COUNT);

    assign enq_ready     = !is_full;
    assign is_queue_full = is_full;
    assign occupancy     = count_reg;

`ifdef UOP_QUEUE_BYPASS_EN
    // Empty queue with a live, unblocked enqueue: present it directly.
    assign bypass_active = is_empty && enq_valid && !stall_queue && !flush_queue;
`else
    assign bypass_active = 1'b0;
`endif

    // A bypassed entry that execute takes right away never touches storage.
    assign bypass_take = bypass_active && deq_ready;

    assign valid_decode = !is_empty || bypass_active;
    assign push         = enq_valid && enq_ready && !flush_queue;
    assign pop          = valid_decode && deq_ready && !stall_queue && !flush_queue;
    assign do_write     = push && !bypass_take;
    assign do_pop       = pop && !is_empty;

    assign wr_data   = {enq_instr, enq_pc, enq_fault, enq_mal};
    assign head_data = entry_q[rd_ptr_reg];

    // Head view: bypassed enqueue when active, otherwise the entry at rd_ptr.
    always_comb begin
        {deq_instr, pc_decode, deq_fault, deq_mal} = head_data;
        if (bypass_active) begin
            {deq_instr, pc_decode, deq_fault, deq_mal} = wr_data;
        end
    end

    // Next pointer / count; flush overrides any same-cycle push or pop.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush_queue) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({do_write, do_pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One register per entry; cleared on reset so the head reads zero after it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            // Capture the enqueued word when the tail points at this slot.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    entry_reg <= '0;
                end else if (do_write && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_stage3_uop_queue.sv
// Testbench for stage3_uop_queue (DEPTH = 4). A scoreboard queue holds the
// entries the queue should contain; each test compares DUT outputs with it
// and with fixed expected PCs.
module tb_stage3_uop_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        enq_valid;
    logic [31:0] enq_instr;
    logic [31:0] enq_pc;
    logic        enq_fault;
    logic        enq_mal;
    logic        enq_ready;
    logic        valid_decode;
    logic [31:0] deq_instr;
    logic [31:0] pc_decode;
    logic        deq_fault;
    logic        deq_mal;
    logic        deq_ready;
    logic        stall_queue;
    logic        flush_queue;
    logic        is_queue_full;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    logic [65:0] sb[$];

    stage3_uop_queue #(.DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .enq_valid     (enq_valid),
        .enq_instr     (enq_instr),
        .enq_pc        (enq_pc),
        .enq_fault     (enq_fault),
        .enq_mal       (enq_mal),
        .enq_ready     (enq_ready),
        .valid_decode  (valid_decode),
        .deq_instr     (deq_instr),
        .pc_decode     (pc_decode),
        .deq_fault     (deq_fault),
        .deq_mal       (deq_mal),
        .deq_ready     (deq_ready),
        .stall_queue   (stall_queue),
        .flush_queue   (flush_queue),
        .is_queue_full (is_queue_full),
        .occupancy     (occupancy)
    );

    always #5 CLK = ~CLK;

    // Instruction word and flags are derived from the PC so every entry is unique.
    function automatic logic [65:0] make_entry(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0], pc, pc[2], pc[3]};
    endfunction

    task automatic drive_enq(input logic v, input logic [31:0] pc);
        logic [65:0] e;
        e = make_entry(pc);
        enq_valid = v;
        {enq_instr, enq_pc, enq_fault, enq_mal} = e;
    endtask

    // Advance one clock and update the scoreboard from the driven inputs.
    task automatic tick();
        logic byp, push_m, pop_m;
        @(negedge CLK);
`ifdef UOP_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && enq_valid && !stall_queue && !flush_queue;
`else
        byp = 1'b0;
`endif
        push_m = enq_valid && (sb.size() != DEPTH) && !flush_queue;
        pop_m  = ((sb.size() != 0) || byp) && deq_ready && !stall_queue && !flush_queue;
        @(posedge CLK);
        #1;
        if (flush_queue) begin
            $display("t=%0t flush (%0d entries dropped)", $time, sb.size());
            sb.delete();
        end else begin
            if (pop_m) $display("t=%0t pop  pc=%h%s", $time, pc_decode, byp ? " (bypass)" : "");
            if (pop_m && sb.size() != 0) void'(sb.pop_front());
            if (push_m && !(byp && deq_ready)) begin
                sb.push_back(make_entry(enq_pc));
                $display("t=%0t push pc=%h", $time, enq_pc);
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive_enq(1'b0, 32'h0);
        deq_ready = 1'b0; stall_queue = 1'b0; flush_queue = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({enq_ready, valid_decode, is_queue_full, occupancy} !== 6'b100_000) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b vld=%b full=%b occ=%0d want 1 0 0 0",
                     enq_ready, valid_decode, is_queue_full, occupancy);
        end
        checks++;
        if ({deq_instr, pc_decode, deq_fault, deq_mal} !== 66'h0) begin
            errors++;
            $display("FAIL reset_head: got instr=%h pc=%h want 0", deq_instr, pc_decode);
        end
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_fill();
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_enq(1'b1, 32'h200 + 32'(4 * i));
            tick();
            checks++;
            if (occupancy !== 3'(sb.size()) || valid_decode !== 1'b1) begin
                errors++;
                $display("FAIL fill_occ[%0d]: got occ=%0d vld=%b want occ=%0d vld=1",
                         i, occupancy, valid_decode, sb.size());
            end
        end
        checks++;
        if ({is_queue_full, enq_ready, occupancy} !== 5'b10_100) begin
            errors++;
            $display("FAIL fill_full: got full=%b rdy=%b occ=%0d want 1 0 4",
                     is_queue_full, enq_ready, occupancy);
        end
        drive_enq(1'b1, 32'h210);
        tick();
        checks++;
        if (occupancy !== 3'd4 || pc_decode !== 32'h200) begin
            errors++;
            $display("FAIL fill_overflow: got occ=%0d head=%h want 4 00000200", occupancy, pc_decode);
        end
        drive_enq(1'b0, 32'h0);
    endtask

    task automatic test_drain();
        deq_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_decode !== 1'b1 || pc_decode !== 32'h200 + 32'(4 * i) ||
                sb.size() == 0 || {deq_instr, pc_decode, deq_fault, deq_mal} !== sb[0]) begin
                errors++;
                $display("FAIL drain_head[%0d]: got vld=%b pc=%h instr=%h want pc=%h",
                         i, valid_decode, pc_decode, deq_instr, 32'h200 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (valid_decode !== 1'b0 || occupancy !== 3'd0 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got vld=%b occ=%0d rdy=%b want 0 0 1",
                     valid_decode, occupancy, enq_ready);
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        deq_ready = 1'b0;
        drive_enq(1'b1, 32'h400);
        tick();
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_enq(1'b1, 32'h404 + 32'(4 * i));
            #1;
            checks++;
            if (valid_decode !== 1'b1 || occupancy !== 3'd1 || pc_decode !== 32'h400 + 32'(4 * i) ||
                sb.size() == 0 || {deq_instr, pc_decode, deq_fault, deq_mal} !== sb[0]) begin
                errors++;
                $display("FAIL stream[%0d]: got vld=%b occ=%0d pc=%h want 1 1 %h",
                         i, valid_decode, occupancy, pc_decode, 32'h400 + 32'(4 * i));
            end
            tick();
        end
        drive_enq(1'b0, 32'h0);
        #1;
        checks++;
        if (pc_decode !== 32'h428) begin
            errors++;
            $display("FAIL stream_last: got pc=%h want 00000428", pc_decode);
        end
        tick();
        checks++;
        if (occupancy !== 3'd0 || valid_decode !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty: got occ=%0d vld=%b want 0 0", occupancy, valid_decode);
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_stall();
        deq_ready = 1'b0;
        drive_enq(1'b1, 32'h500); tick();
        drive_enq(1'b1, 32'h504); tick();
        stall_queue = 1'b1;
        deq_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 32'h508 + 32'(4 * i));
            #1;
            checks++;
            if (pc_decode !== 32'h500 || valid_decode !== 1'b1) begin
                errors++;
                $display("FAIL stall_head[%0d]: got pc=%h vld=%b want 00000500 1", i, pc_decode, valid_decode);
            end
            tick();
        end
        checks++;
        if (occupancy !== 3'd4 || is_queue_full !== 1'b1) begin
            errors++;
            $display("FAIL stall_fill: got occ=%0d full=%b want 4 1", occupancy, is_queue_full);
        end
        stall_queue = 1'b0;
        drive_enq(1'b0, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_decode !== 32'h500 + 32'(4 * i) || sb.size() == 0 ||
                {deq_instr, pc_decode, deq_fault, deq_mal} !== sb[0]) begin
                errors++;
                $display("FAIL stall_drain[%0d]: got pc=%h want %h", i, pc_decode, 32'h500 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL stall_empty: got occ=%0d want 0", occupancy);
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_flush();
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 32'h600 + 32'(4 * i));
            tick();
        end
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: got occ=%0d want 3", occupancy);
        end
        flush_queue = 1'b1;
        deq_ready   = 1'b1;
        drive_enq(1'b1, 32'h60C);
        tick();
        flush_queue = 1'b0;
        deq_ready   = 1'b0;
        drive_enq(1'b0, 32'h0);
        #1;
        checks++;
        if (occupancy !== 3'd0 || valid_decode !== 1'b0 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got occ=%0d vld=%b rdy=%b want 0 0 1",
                     occupancy, valid_decode, enq_ready);
        end
        drive_enq(1'b1, 32'h700);
        tick();
        drive_enq(1'b0, 32'h0);
        #1;
        checks++;
        if (occupancy !== 3'd1 || pc_decode !== 32'h700 || sb.size() != 1) begin
            errors++;
            $display("FAIL flush_after: got occ=%0d pc=%h want 1 00000700", occupancy, pc_decode);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic test_bypass();
        deq_ready = 1'b1;
        drive_enq(1'b1, 32'h300);
        #1;
`ifdef UOP_QUEUE_BYPASS_EN
        checks++;
        if (valid_decode !== 1'b1 || pc_decode !== 32'h300 || deq_instr !== 32'h0300_FCFF) begin
            errors++;
            $display("FAIL bypass_same: got vld=%b pc=%h instr=%h want 1 00000300 0300fcff",
                     valid_decode, pc_decode, deq_instr);
        end
        tick();
        drive_enq(1'b0, 32'h0);
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL bypass_occ: got occ=%0d want 0", occupancy);
        end
`else
        checks++;
        if (valid_decode !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same: got vld=%b want 0", valid_decode);
        end
        tick();
        drive_enq(1'b0, 32'h0);
        #1;
        checks++;
        if (valid_decode !== 1'b1 || pc_decode !== 32'h300 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL nobypass_next: got vld=%b pc=%h occ=%0d want 1 00000300 1",
                     valid_decode, pc_decode, occupancy);
        end
        tick();
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL nobypass_drain: got occ=%0d want 0", occupancy);
        end
`endif
        deq_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        deq_ready = 1'b0;
        drive_enq(1'b1, 32'h800); tick();
        drive_enq(1'b1, 32'h804); tick();
        drive_enq(1'b0, 32'h0);
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (occupancy !== 3'd0 || valid_decode !== 1'b0 || enq_ready !== 1'b1 ||
            pc_decode !== 32'h0 || deq_instr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got occ=%0d vld=%b rdy=%b pc=%h instr=%h want 0 0 1 0 0",
                     occupancy, valid_decode, enq_ready, pc_decode, deq_instr);
        end
        sb.delete();
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_stall();
        test_flush();
        test_bypass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
